cucpu: RTL and testbench

Control unit / sequencer for the 8-bit accumulator CPU. Consumes the 4-bit opcode nibble produced by the instruction register (`IRcu`) and steps a six-state T-cycle sequencer (fetch T1–T3, execute T4–T6). It decodes opcode and T-state into the per-cycle control lines for the PC, MAR, RAM, IR, accumulator, B register, ALU and output register, and halts on `HLT`.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/ringcpu.sv | 52 +++++
 rtl/cucpu.sv | 117 +++++++++++
 tb/tb_cucpu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit accumulator CPU control path.
//   - Opcode constants (upper nibble of an instruction).
//   - T-state encoding of the sequencer (T1..T6 = 0..5, HALT = 7).
//   - Control-word bit indices, shared with the datapath so both sides
//     agree on which bit of a packed control word means what.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Sequencer states. Code 6 is unused and recovers to T1.
  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_T6   = 3'd5,
    ST_HALT = 3'd7
  } tstate_t;

  // Control-word bit indices
  localparam int CW_PC_OUT    = 0;
  localparam int CW_PC_INC    = 1;
  localparam int CW_PC_LOAD   = 2;
  localparam int CW_MAR_LOAD  = 3;
  localparam int CW_RAM_OUT   = 4;
  localparam int CW_RAM_WRITE = 5;
  localparam int CW_IR_LOAD   = 6;
  localparam int CW_IR_OUT    = 7;
  localparam int CW_ACC_LOAD  = 8;
  localparam int CW_ACC_OUT   = 9;
  localparam int CW_BREG_LOAD = 10;
  localparam int CW_ALU_SUB   = 11;
  localparam int CW_ALU_OUT   = 12;
  localparam int CW_OUT_LOAD  = 13;
  localparam int CW_W         = 14;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // One-hot control word with only bit idx set.
  function automatic ctrl_word_t cw_bit(input int idx);
    ctrl_word_t w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/ringcpu.sv
// -----------------------------------------------------------------------------
// ringcpu
// T-state counter of the control unit. Walks T1..T6 in a ring and parks in
// HALT when the decoder requests it during T4.
// Ports:
//   clk      in   system clock, all state changes on posedge
//   clear    in   synchronous active-high reset, forces T1 (wins over run)
//   run      in   advance enable; 0 holds the current state
//   hlt_req  in   from decode: HLT seen in T4, go to HALT instead of T5
//   state_o  out  current state (registered)
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module ringcpu (
  input  logic    clk,
  input  logic    clear,
  input  logic    run,
  input  logic    hlt_req,
  output tstate_t state_o
);

  tstate_t state_q;
  tstate_t state_d;

  always_comb begin
    state_d = state_q;
    if (run) begin
      case (state_q)
        ST_T1:   state_d = ST_T2;
        ST_T2:   state_d = ST_T3;
        ST_T3:   state_d = ST_T4;
        ST_T4:   state_d = hlt_req ? ST_HALT : ST_T5;
        ST_T5:   state_d = ST_T6;
        ST_T6:   state_d = ST_T1;
        // HALT is left only through clear.
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_T1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_T1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/cucpu.sv
// -----------------------------------------------------------------------------
// cucpu
// Control unit of the 8-bit accumulator CPU. Decodes the sequencer T-state
// and the IR opcode nibble into the per-cycle control lines.
// Ports:
//   clk, clear          clock / synchronous active-high reset
//   run                 sequencer enable; 0 freezes state and zeroes controls
//   IRcu[3:0]           opcode from the instruction register (valid T4..T6)
//   pc_out/pc_inc/pc_load, mar_load, ram_out/ram_write, ir_load/ir_out,
//   acc_load/acc_out, breg_load, alu_sub/alu_out, out_load
//                       control lines (combinational, gated by ~clear & run)
//   halted              sequencer is parked in HALT
//   t_state[2:0]        current state code (debug)
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module cucpu (
  input  logic       clk,
  input  logic       clear,
  input  logic       run,
  input  logic [3:0] IRcu,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_write,
  output logic       ir_load,
  output logic       ir_out,
  output logic       acc_load,
  output logic       acc_out,
  output logic       breg_load,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] t_state
);

  tstate_t    state;
  logic       hlt_req;
  logic       ctrl_en;
  ctrl_word_t cw_raw;
  ctrl_word_t cw;

  // HLT ends the instruction at T4; the sequencer moves to HALT.
  assign hlt_req = (state == ST_T4) && (IRcu == OP_HLT);

  ringcpu u_ring (
    .clk     (clk),
    .clear   (clear),
    .run     (run),
    .hlt_req (hlt_req),
    .state_o (state)
  );

  // Raw decode of state and opcode. IRcu is only looked at in T4..T6,
  // since the IR is still loading during fetch.
  always_comb begin
    cw_raw = '0;
    case (state)
      ST_T1: cw_raw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
      ST_T2: cw_raw = cw_bit(CW_PC_INC);
      ST_T3: cw_raw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD);
      ST_T4: begin
        case (IRcu)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            cw_raw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
          OP_JMP:  cw_raw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
          OP_OUT:  cw_raw = cw_bit(CW_ACC_OUT) | cw_bit(CW_OUT_LOAD);
          default: cw_raw = '0;
        endcase
      end
      ST_T5: begin
        case (IRcu)
          OP_LDA:         cw_raw = cw_bit(CW_RAM_OUT) | cw_bit(CW_ACC_LOAD);
          OP_ADD, OP_SUB: cw_raw = cw_bit(CW_RAM_OUT) | cw_bit(CW_BREG_LOAD);
          OP_STA:         cw_raw = cw_bit(CW_ACC_OUT) | cw_bit(CW_RAM_WRITE);
          default:        cw_raw = '0;
        endcase
      end
      ST_T6: begin
        case (IRcu)
          OP_ADD:  cw_raw = cw_bit(CW_ALU_OUT) | cw_bit(CW_ACC_LOAD);
          OP_SUB:  cw_raw = cw_bit(CW_ALU_OUT) | cw_bit(CW_ACC_LOAD)
                          | cw_bit(CW_ALU_SUB);
          default: cw_raw = '0;
        endcase
      end
      default: cw_raw = '0;
    endcase
  end

  // Gating by clear makes the reset cycle silent even though the state
  // register still holds its pre-reset value until the edge.
  assign ctrl_en = ~clear & run;
  assign cw      = cw_raw & {CW_W{ctrl_en}};

  assign pc_out    = cw[CW_PC_OUT];
  assign pc_inc    = cw[CW_PC_INC];
  assign pc_load   = cw[CW_PC_LOAD];
  assign mar_load  = cw[CW_MAR_LOAD];
  assign ram_out   = cw[CW_RAM_OUT];
  assign ram_write = cw[CW_RAM_WRITE];
  assign ir_load   = cw[CW_IR_LOAD];
  assign ir_out    = cw[CW_IR_OUT];
  assign acc_load  = cw[CW_ACC_LOAD];
  assign acc_out   = cw[CW_ACC_OUT];
  assign breg_load = cw[CW_BREG_LOAD];
  assign alu_sub   = cw[CW_ALU_SUB];
  assign alu_out   = cw[CW_ALU_OUT];
  assign out_load  = cw[CW_OUT_LOAD];

  assign halted  = (state == ST_HALT) & ~clear;
  assign t_state = state;

endmodule

// File: tb/tb_cucpu.sv
// -----------------------------------------------------------------------------
// tb_cucpu
// Directed bench for the control unit. Inputs change 2 time units after a
// rising edge and outputs are sampled before the next one.
// -----------------------------------------------------------------------------
module tb_cucpu;

  logic       clk;
  logic       clear;
  logic       run;
  logic [3:0] IRcu;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write;
  logic       ir_load, ir_out, acc_load, acc_out, breg_load;
  logic       alu_sub, alu_out, out_load, halted;
  logic [2:0] t_state;

  int errors;
  int checks;

  // Bench-local packing of the control lines, MSB first.
  logic [13:0] cw;
  logic [4:0]  bus;
  assign cw  = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, ir_load,
                ir_out, acc_load, acc_out, breg_load, alu_sub, alu_out, out_load};
  assign bus = {pc_out, ram_out, ir_out, acc_out, alu_out};

  localparam logic [13:0] C_PC_OUT    = 14'b10000000000000;
  localparam logic [13:0] C_PC_INC    = 14'b01000000000000;
  localparam logic [13:0] C_PC_LOAD   = 14'b00100000000000;
  localparam logic [13:0] C_MAR_LOAD  = 14'b00010000000000;
  localparam logic [13:0] C_RAM_OUT   = 14'b00001000000000;
  localparam logic [13:0] C_RAM_WRITE = 14'b00000100000000;
  localparam logic [13:0] C_IR_LOAD   = 14'b00000010000000;
  localparam logic [13:0] C_IR_OUT    = 14'b00000001000000;
  localparam logic [13:0] C_ACC_LOAD  = 14'b00000000100000;
  localparam logic [13:0] C_ACC_OUT   = 14'b00000000010000;
  localparam logic [13:0] C_BREG_LOAD = 14'b00000000001000;
  localparam logic [13:0] C_ALU_SUB   = 14'b00000000000100;
  localparam logic [13:0] C_ALU_OUT   = 14'b00000000000010;
  localparam logic [13:0] C_OUT_LOAD  = 14'b00000000000001;
  localparam logic [13:0] C_NONE      = 14'b0;

  cucpu dut (
    .clk       (clk),
    .clear     (clear),
    .run       (run),
    .IRcu      (IRcu),
    .pc_out    (pc_out),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .mar_load  (mar_load),
    .ram_out   (ram_out),
    .ram_write (ram_write),
    .ir_load   (ir_load),
    .ir_out    (ir_out),
    .acc_load  (acc_load),
    .acc_out   (acc_out),
    .breg_load (breg_load),
    .alu_sub   (alu_sub),
    .alu_out   (alu_out),
    .out_load  (out_load),
    .halted    (halted),
    .t_state   (t_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives one full instruction starting in T1 and checks all six cycles.
  // IRcu carries the complement of the opcode during fetch to show that it
  // is ignored there.
  task automatic exec_instr(input string name, input logic [3:0] op,
                            input logic [13:0] e4, input logic [13:0] e5,
                            input logic [13:0] e6);
    logic [13:0] exp_cw [6];
    exp_cw[0] = C_PC_OUT | C_MAR_LOAD;
    exp_cw[1] = C_PC_INC;
    exp_cw[2] = C_RAM_OUT | C_IR_LOAD;
    exp_cw[3] = e4;
    exp_cw[4] = e5;
    exp_cw[5] = e6;
    IRcu = ~op;
    #1;
    for (int t = 0; t < 6; t++) begin
      checks++;
      if (cw !== exp_cw[t]) begin
        errors++;
        $display("FAIL %s T%0d cw: got %b expected %b", name, t + 1, cw, exp_cw[t]);
      end
      checks++;
      if (t_state !== 3'(t)) begin
        errors++;
        $display("FAIL %s T%0d t_state: got %0d expected %0d", name, t + 1, t_state, t);
      end
      checks++;
      if ($countones(bus) > 1) begin
        errors++;
        $display("FAIL %s T%0d bus_onehot: got %b expected at most one driver", name, t + 1, bus);
      end
      if (t == 2) IRcu = op;
      tick();
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    run   = 1'b1;
    IRcu  = 4'b1111;
    tick();
    tick();
    checks++;
    if (cw !== C_NONE) begin errors++; $display("FAIL reset cw: got %b expected %b", cw, C_NONE); end
    checks++;
    if (t_state !== 3'd0) begin errors++; $display("FAIL reset t_state: got %0d expected 0", t_state); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset halted: got %b expected 0", halted); end
    clear = 1'b0;
    #1;
    checks++;
    if (cw !== (C_PC_OUT | C_MAR_LOAD)) begin
      errors++; $display("FAIL reset_rel_c1 cw: got %b expected %b", cw, C_PC_OUT | C_MAR_LOAD);
    end
    tick();
    checks++;
    if (cw !== C_PC_INC) begin errors++; $display("FAIL reset_rel_c2 cw: got %b expected %b", cw, C_PC_INC); end
    tick();
    checks++;
    if (cw !== (C_RAM_OUT | C_IR_LOAD)) begin
      errors++; $display("FAIL reset_rel_c3 cw: got %b expected %b", cw, C_RAM_OUT | C_IR_LOAD);
    end
    // Finish this instruction as a NOP (0101) to get back to T1.
    IRcu = 4'b0101;
    for (int t = 3; t < 6; t++) begin
      tick();
      checks++;
      if (cw !== C_NONE || t_state !== 3'(t)) begin
        errors++; $display("FAIL reset_nop T%0d: got cw=%b st=%0d expected cw=%b st=%0d", t + 1, cw, t_state, C_NONE, t);
      end
    end
    tick();
  endtask

  task automatic test_lda();
    exec_instr("lda", 4'b0000, C_IR_OUT | C_MAR_LOAD, C_RAM_OUT | C_ACC_LOAD, C_NONE);
  endtask

  task automatic test_back_to_back();
    exec_instr("sub", 4'b0010, C_IR_OUT | C_MAR_LOAD, C_RAM_OUT | C_BREG_LOAD,
               C_ALU_OUT | C_ACC_LOAD | C_ALU_SUB);
    exec_instr("add", 4'b0001, C_IR_OUT | C_MAR_LOAD, C_RAM_OUT | C_BREG_LOAD,
               C_ALU_OUT | C_ACC_LOAD);
    exec_instr("sta", 4'b0011, C_IR_OUT | C_MAR_LOAD, C_ACC_OUT | C_RAM_WRITE, C_NONE);
    exec_instr("jmp", 4'b0100, C_IR_OUT | C_PC_LOAD, C_NONE, C_NONE);
    exec_instr("out", 4'b1110, C_ACC_OUT | C_OUT_LOAD, C_NONE, C_NONE);
    exec_instr("nop7", 4'b0111, C_NONE, C_NONE, C_NONE);
  endtask

  task automatic test_run_stall();
    IRcu = 4'b1111;
    tick();
    tick();
    IRcu = 4'b0001;
    tick();
    checks++;
    if (cw !== (C_IR_OUT | C_MAR_LOAD)) begin
      errors++; $display("FAIL stall_t4 cw: got %b expected %b", cw, C_IR_OUT | C_MAR_LOAD);
    end
    tick();
    checks++;
    if (cw !== (C_RAM_OUT | C_BREG_LOAD)) begin
      errors++; $display("FAIL stall_t5 cw: got %b expected %b", cw, C_RAM_OUT | C_BREG_LOAD);
    end
    run = 1'b0;
    #1;
    checks++;
    if (cw !== C_NONE) begin errors++; $display("FAIL stall_low cw: got %b expected %b", cw, C_NONE); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cw !== C_NONE || t_state !== 3'd4) begin
        errors++; $display("FAIL stall_hold%0d: got cw=%b st=%0d expected cw=%b st=4", i, cw, t_state, C_NONE);
      end
    end
    run = 1'b1;
    #1;
    checks++;
    if (cw !== (C_RAM_OUT | C_BREG_LOAD) || t_state !== 3'd4) begin
      errors++; $display("FAIL stall_resume: got cw=%b st=%0d expected cw=%b st=4", cw, t_state, C_RAM_OUT | C_BREG_LOAD);
    end
    tick();
    checks++;
    if (cw !== (C_ALU_OUT | C_ACC_LOAD) || t_state !== 3'd5) begin
      errors++; $display("FAIL stall_t6: got cw=%b st=%0d expected cw=%b st=5", cw, t_state, C_ALU_OUT | C_ACC_LOAD);
    end
    tick();
    checks++;
    if (cw !== (C_PC_OUT | C_MAR_LOAD) || t_state !== 3'd0) begin
      errors++; $display("FAIL stall_t1: got cw=%b st=%0d expected cw=%b st=0", cw, t_state, C_PC_OUT | C_MAR_LOAD);
    end
  endtask

  task automatic test_clear_mid();
    IRcu = 4'b0000;
    tick();
    tick();
    IRcu = 4'b0011;
    tick();
    tick();
    checks++;
    if (cw !== (C_ACC_OUT | C_RAM_WRITE)) begin
      errors++; $display("FAIL clr_sta_t5 cw: got %b expected %b", cw, C_ACC_OUT | C_RAM_WRITE);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (cw !== C_NONE) begin errors++; $display("FAIL clr_asserted cw: got %b expected %b", cw, C_NONE); end
    tick();
    checks++;
    if (cw !== C_NONE || t_state !== 3'd0) begin
      errors++; $display("FAIL clr_edge: got cw=%b st=%0d expected cw=%b st=0", cw, t_state, C_NONE);
    end
    clear = 1'b0;
    #1;
    checks++;
    if (cw !== (C_PC_OUT | C_MAR_LOAD)) begin
      errors++; $display("FAIL clr_release cw: got %b expected %b", cw, C_PC_OUT | C_MAR_LOAD);
    end
    exec_instr("post_clr_nop", 4'b0111, C_NONE, C_NONE, C_NONE);
  endtask

  task automatic test_hlt();
    IRcu = 4'b0000;
    tick();
    tick();
    IRcu = 4'b1111;
    tick();
    checks++;
    if (cw !== C_NONE || t_state !== 3'd3 || halted !== 1'b0) begin
      errors++; $display("FAIL hlt_t4: got cw=%b st=%0d halted=%b expected cw=%b st=3 halted=0", cw, t_state, halted, C_NONE);
    end
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 10) IRcu = 4'b0001;
      checks++;
      if (halted !== 1'b1 || cw !== C_NONE || t_state !== 3'd7) begin
        errors++; $display("FAIL hlt_hold%0d: got halted=%b cw=%b st=%0d expected halted=1 cw=%b st=7", i, halted, cw, t_state, C_NONE);
      end
    end
    // clear together with run low: clear wins.
    run   = 1'b0;
    clear = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL hlt_clr_halted: got %b expected 0", halted); end
    tick();
    checks++;
    if (t_state !== 3'd0 || cw !== C_NONE) begin
      errors++; $display("FAIL hlt_clr_edge: got st=%0d cw=%b expected st=0 cw=%b", t_state, cw, C_NONE);
    end
    clear = 1'b0;
    run   = 1'b1;
    #1;
    checks++;
    if (cw !== (C_PC_OUT | C_MAR_LOAD) || halted !== 1'b0) begin
      errors++; $display("FAIL hlt_restart: got cw=%b halted=%b expected cw=%b halted=0", cw, halted, C_PC_OUT | C_MAR_LOAD);
    end
    exec_instr("after_hlt_lda", 4'b0000, C_IR_OUT | C_MAR_LOAD, C_RAM_OUT | C_ACC_LOAD, C_NONE);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear  = 1'b1;
    run    = 1'b0;
    IRcu   = 4'b0000;
    test_reset();
    test_lda();
    test_back_to_back();
    test_run_stall();
    test_clear_mid();
    test_hlt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
